fetch_stage_buffered: RTL and testbench
=======================================

Name: fetch_stage_buffered

Overview:
- Parametrised next-generation fetch stage for the RISC-V pipeline core.
- Decouples PC generation from instruction memory using a valid/ready request port and a variable-latency response port.
- Holds fetched instructions in a DEPTH-entry prefetch queue, then drives the Fetch->Decode pipeline register.
- Supports a Decode stall from the hazard unit, and an Execute-stage redirect that flushes in-flight work and all queued work.

Parameters:
XLEN, 32, PC/address width (instructions are always 32 bits)
RESET_PC, 0, PC value loaded on reset
DEPTH, 4, prefetch queue entries; power of two, >= 2
NOP_INSTR, 32'h00000013, instruction driven on instr_d when valid_d=0 (addi x0,x0,0)

Ports:
clock  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
redirect_e  in  1  taken branch/jump resolved in Execute
redirect_pc_e  in  XLEN  redirect target
stall_d  in  1  hold Decode register (load-use stall)
imem_req_valid  out  1  fetch request
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address (= pc_f)
imem_resp_valid  in  1  response data valid (one per accepted request, in order)
imem_resp_data  in  32  fetched instruction
instr_d  out  32  Decode instruction
pc_d  out  XLEN  Decode PC
pc_plus4_d  out  XLEN  Decode PC+4
valid_d  out  1  Decode register holds a real instruction

Behaviour:
- Reset (asynchronous, active-high): pc_f=RESET_PC; queue empty; outstanding=0; drop_pending=0; valid_d=0; instr_d=NOP_INSTR; pc_d=0; pc_plus4_d=0.
- Request issue:
  - imem_req_valid = !outstanding && count<DEPTH && !redirect_e.
  - At most one request outstanding.
  - On req_valid && req_ready: outstanding<=1; pc_f<=pc_f+4, modulo 2^XLEN (0xFFFFFFFC wraps to 0).
- Response:
  - imem_resp_valid while outstanding=1 clears outstanding.
  - If drop_pending=0 and redirect_e=0: push {pc, instr} into the queue. Slot is guaranteed, because issue required count<DEPTH.
  - If drop_pending=1: discard the data and clear drop_pending.
  - imem_resp_valid while outstanding=0: ignored; flagged by a bench assertion.
- Queue:
  - Synchronous FIFO with no bypass.
  - A pushed entry is visible at the head one edge after its push.
  - Simultaneous push and pop are allowed when non-empty; count is unchanged.
- Decode register, on each edge when redirect_e=0:
  - stall_d=1: hold all D outputs; no pop.
  - stall_d=0 and queue non-empty: load head into instr_d/pc_d, set pc_plus4_d=pc+4 and valid_d=1, pop.
  - stall_d=0 and queue empty: valid_d=0, instr_d=NOP_INSTR; pc_d/pc_plus4_d hold.
- Redirect (redirect_e=1), which wins over stall_d and over any push or pop in that cycle:
  - pc_f<=redirect_pc_e.
  - Queue cleared (count=0).
  - valid_d<=0, instr_d<=NOP_INSTR.
  - If outstanding=1 and no response arrives this cycle: drop_pending<=1.
  - No request is issued that cycle.
- Latency:
  - Redirect at edge N means pc_f=target after N.
  - With ready=1 and a 1-cycle response, the request is issued in the cycle after N and the response arrives in the cycle after that.
  - The instruction is pushed at edge N+2 and valid_d=1 after edge N+3.
- Steady-state throughput: one instruction per 2 cycles with 1-cycle memory, limited by the single-outstanding-request rule. Accepted for this generation.
- Reset mid-request: all state is cleared. A later stray response is ignored (outstanding=0).

Decomposition:
- Package fetch_pkg: NOP_INSTR default constant; fetch_entry_t struct {pc[XLEN], instr[32]}, parametrised via the package XLEN constant.
- Sub-module fetch_queue: DEPTH-entry synchronous FIFO with push, pop, clear, count, full and empty, using the same clock/reset.
- Everything else (PC register, request control, drop logic, D register) lives in the top module.

Test Plan:
- Reset with RESET_PC=0x100, 1-cycle memory, ready=1: req addrs are 0x100, 0x104, 0x108 on alternate cycles; D receives pc_d=0x100, 0x104 in order with pc_plus4_d=pc_d+4, valid_d=1; valid_d=0 (instr_d=0x13) before the first.
- stall_d held 6 cycles: D outputs frozen; queue fills to DEPTH=4; req_valid drops to 0. On release, D sees 4 consecutive valid instructions, with no loss or duplication.
- Redirect to 0x200 while a response for 0x10C is outstanding with 3-cycle latency: the 0x10C response is discarded. The next request addr is 0x200 and the next valid pc_d is 0x200. valid_d=0 in the cycle after the redirect.
- Redirect and stall_d both asserted in the same cycle: flush still occurs and valid_d=0.
- PC wrap: redirect to 0xFFFFFFFC gives request addrs 0xFFFFFFFC, 0x00000000; pc_plus4_d=0x00000000 for the first.
- Assert reset for 1 cycle mid-request, with imem_resp_valid pulsed afterwards: all outputs return to reset values; the stray response does not enter the queue; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the buffered fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO: synchronous, no bypass; clear has priority over push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  input  logic                     clear,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t   slots [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           push_ok;
  logic           pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full && !clear;
  assign pop_ok  = pop && !empty && !clear;
  assign head    = slots[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) begin
      slots[wr_ptr] <= push_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage_buffered.sv
// Fetch stage: PC generation, single-outstanding imem request port,
// prefetch queue and the Fetch->Decode pipeline register.
module fetch_stage_buffered
  import fetch_pkg::*;
#(
  parameter int unsigned       XLEN      = FETCH_XLEN,
  parameter logic [XLEN-1:0]   RESET_PC  = '0,
  parameter int unsigned       DEPTH     = 4,
  parameter logic [31:0]       NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_e,
  input  logic [XLEN-1:0] redirect_pc_e,
  input  logic            stall_d,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] req_pc;
  logic            outstanding;
  logic            drop_pending;

  logic            req_fire;
  logic            resp_accept;
  logic            q_push;
  logic            q_pop;
  fetch_entry_t    q_push_entry;
  fetch_entry_t    q_head;
  logic [CW-1:0]   q_count;
  logic            unused_q_full;
  logic            q_empty;
  logic [XLEN-1:0] head_pc;

  assign imem_req_valid = !outstanding && (q_count < CW'(DEPTH)) && !redirect_e;
  assign imem_req_addr  = pc_f;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_accept    = imem_resp_valid && outstanding;

  // A response that lands in a redirect cycle is consumed but never queued.
  assign q_push = resp_accept && !drop_pending && !redirect_e;
  assign q_pop  = !redirect_e && !stall_d && !q_empty;

  always_comb begin
    q_push_entry       = '0;
    q_push_entry.pc    = req_pc;
    q_push_entry.instr = imem_resp_data;
  end

  assign head_pc = q_head.pc;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clock      (clock),
    .reset      (reset),
    .push       (q_push),
    .push_entry (q_push_entry),
    .pop        (q_pop),
    .clear      (redirect_e),
    .head       (q_head),
    .count      (q_count),
    .full       (unused_q_full),
    .empty      (q_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_f         <= RESET_PC;
      req_pc       <= '0;
      outstanding  <= 1'b0;
      drop_pending <= 1'b0;
    end else begin
      if (redirect_e) begin
        pc_f <= redirect_pc_e;
      end else if (req_fire) begin
        pc_f <= pc_f + XLEN'(4);
      end

      if (req_fire) begin
        outstanding <= 1'b1;
        req_pc      <= pc_f;
      end else if (resp_accept) begin
        outstanding <= 1'b0;
      end

      // The in-flight request belongs to the flushed path; its data must be discarded.
      if (redirect_e && outstanding && !imem_resp_valid) begin
        drop_pending <= 1'b1;
      end else if (resp_accept) begin
        drop_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_d    <= 1'b0;
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
    end else if (redirect_e) begin
      valid_d <= 1'b0;
      instr_d <= NOP_INSTR;
    end else if (!stall_d) begin
      if (!q_empty) begin
        valid_d    <= 1'b1;
        instr_d    <= q_head.instr;
        pc_d       <= head_pc;
        pc_plus4_d <= head_pc + XLEN'(4);
      end else begin
        valid_d <= 1'b0;
        instr_d <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage_buffered.sv
// Directed + randomized bench for fetch_stage_buffered with a queue-based reference model.
module tb_fetch_stage_buffered;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        redirect_e;
  logic [31:0] redirect_pc_e;
  logic        stall_d;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;

  fetch_stage_buffered #(
    .XLEN      (32),
    .RESET_PC  (RPC),
    .DEPTH     (DEPTH),
    .NOP_INSTR (NOP)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .redirect_e      (redirect_e),
    .redirect_pc_e   (redirect_pc_e),
    .stall_d         (stall_d),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_d         (instr_d),
    .pc_d            (pc_d),
    .pc_plus4_d      (pc_plus4_d),
    .valid_d         (valid_d)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Reference model state
  logic [31:0] m_pc, m_reqpc;
  bit          m_out, m_drop;
  ent_t        mq[$];
  bit          m_vd;
  logic [31:0] m_instr, m_pcd, m_pcp4;

  // Memory environment
  bit          mem_pend;
  int unsigned mem_rem;
  logic [31:0] mem_addr;
  int unsigned lat_min, lat_max;

  int errors, checks, strays;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_reqpc = '0; m_out = 0; m_drop = 0; mq.delete();
    m_vd = 0; m_instr = NOP; m_pcd = '0; m_pcp4 = '0;
    mem_pend = 0; mem_rem = 0; mem_addr = '0;
    imem_resp_valid = 1'b0; imem_resp_data = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid_d"}, {31'b0, valid_d}, 32'd0);
    chk({tag, "_instr_d"}, instr_d, NOP);
    chk({tag, "_pc_d"}, pc_d, 32'd0);
    chk({tag, "_pc_plus4_d"}, pc_plus4_d, 32'd0);
    chk({tag, "_req_addr"}, imem_req_addr, RPC);
  endtask

  task automatic cycle(input bit rd, input logic [31:0] rpc, input bit st, input bit rdy);
    bit m_req, fire, resp, dut_fire, resp_was;
    logic [31:0] a;
    ent_t e;
    redirect_e = rd; redirect_pc_e = rpc; stall_d = st; imem_req_ready = rdy;
    #2;
    m_req = !m_out && (mq.size() < DEPTH) && !rd;
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, m_req});
    if (m_req) chk("req_addr", imem_req_addr, m_pc);
    if (imem_resp_valid && !m_out) strays++;
    dut_fire = imem_req_valid && rdy;
    a        = imem_req_addr;
    resp_was = imem_resp_valid;
    fire     = m_req && rdy;
    resp     = imem_resp_valid && m_out;

    if (rd) begin
      m_vd = 0; m_instr = NOP;
    end else if (!st) begin
      if (mq.size() > 0) begin
        e = mq.pop_front();
        m_vd = 1; m_instr = e.instr; m_pcd = e.pc; m_pcp4 = e.pc + 32'd4;
      end else begin
        m_vd = 0; m_instr = NOP;
      end
    end
    if (resp) begin
      if (!m_drop && !rd) mq.push_back('{m_reqpc, imem(m_reqpc)});
      m_drop = 0; m_out = 0;
    end
    if (rd && m_out && !imem_resp_valid) m_drop = 1;
    if (rd) mq.delete();
    if (fire) begin
      m_out = 1; m_reqpc = m_pc; m_pc = m_pc + 32'd4;
    end
    if (rd) m_pc = rpc;

    @(posedge clock);
    #1;
    chk("valid_d", {31'b0, valid_d}, {31'b0, m_vd});
    chk("instr_d", instr_d, m_instr);
    chk("pc_d", pc_d, m_pcd);
    chk("pc_plus4_d", pc_plus4_d, m_pcp4);

    if (resp_was) mem_pend = 0;
    if (dut_fire) begin
      mem_pend = 1; mem_rem = $urandom_range(lat_max, lat_min); mem_addr = a;
    end else if (mem_pend) begin
      mem_rem--;
    end
    imem_resp_valid = mem_pend && (mem_rem == 1);
    imem_resp_data  = imem_resp_valid ? imem(mem_addr) : $urandom;
  endtask

  initial begin
    bit seen, rd, st, rdy, found;
    logic [31:0] r;
    errors = 0; checks = 0; strays = 0;
    lat_min = 1; lat_max = 1;
    reset = 1'b1; redirect_e = 0; redirect_pc_e = '0; stall_d = 0; imem_req_ready = 0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    reset = 1'b0;

    // Straight-line fetch from RESET_PC with 1-cycle memory
    repeat (10) cycle(0, '0, 0, 1);

    // Long decode stall fills the queue, then drains in order
    repeat (10) cycle(0, '0, 1, 1);
    repeat (12) cycle(0, '0, 0, 1);

    // Redirect while a slow response is still in flight
    lat_min = 3; lat_max = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(0, '0, 0, 1);
      found = m_out && !imem_resp_valid;
    end
    chk("wait_outstanding", {31'b0, found}, 32'd1);
    cycle(1, 32'h0000_0200, 0, 1);
    chk("redirect_flush_valid", {31'b0, valid_d}, 32'd0);
    repeat (14) cycle(0, '0, 0, 1);
    lat_min = 1; lat_max = 1;

    // Redirect and stall in the same cycle
    cycle(0, '0, 1, 1);
    cycle(1, 32'h0000_0300, 1, 1);
    chk("redirect_stall_valid", {31'b0, valid_d}, 32'd0);
    repeat (8) cycle(0, '0, 0, 1);

    // PC wrap
    cycle(1, 32'hFFFF_FFFC, 0, 1);
    seen = 0;
    repeat (8) begin
      cycle(0, '0, 0, 1);
      if (valid_d && pc_d == 32'hFFFF_FFFC) begin
        seen = 1;
        chk("wrap_pc_plus4", pc_plus4_d, 32'd0);
      end
    end
    chk("wrap_seen", {31'b0, seen}, 32'd1);

    // Reset mid-request followed by a stray response
    lat_min = 3; lat_max = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(0, '0, 0, 1);
      found = m_out;
    end
    chk("wait_outstanding_rst", {31'b0, found}, 32'd1);
    reset = 1'b1;
    #2;
    check_reset_outputs("midreset");
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    lat_min = 1; lat_max = 1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    repeat (10) cycle(0, '0, 0, 1);
    chk("stray_count", strays, 32'd1);

    // Randomized traffic
    lat_min = 1; lat_max = 3;
    repeat (400) begin
      rd  = ($urandom_range(19, 0) == 0);
      st  = ($urandom_range(3, 0) == 0);
      rdy = ($urandom_range(9, 0) < 7);
      r   = $urandom;
      r[1:0] = 2'b00;
      cycle(rd, r, st, rdy);
    end
    chk("stray_count_final", strays, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
